// File: rtl/ammrv2axi_pkg.sv
// Shared constants and helpers for the pipelined Avalon-MM to AXI4-Lite bridge.
// Covers response codes, counter sizing and read transfer-size derivation.
package ammrv2axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Width needed to hold the values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

  // One byte lane gives size 0.
  // One naturally aligned byte pair gives size 1.
  // Anything else uses the full bus width.
  function automatic logic [2:0] calc_arsize(input logic [7:0] be, input int dbytes);
    int   ones;
    logic pair;
    ones = 0;
    pair = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (be[i]) ones++;
    end
    for (int k = 0; k < 4; k++) begin
      if (be == (8'h03 << (2 * k))) pair = 1'b1;
    end
    if (ones == 1) return 3'd0;
    if (pair) return 3'd1;
    case (dbytes)
      1:       return 3'd0;
      2:       return 3'd1;
      4:       return 3'd2;
      default: return 3'd3;
    endcase
  endfunction

endpackage

// File: rtl/ammrv2axi_ostcnt.sv
// Outstanding-transaction counter for one bridge direction.
// Increments on accept and decrements on response; never drops below zero.
module ammrv2axi_ostcnt
  import ammrv2axi_pkg::*;
#(
  parameter int P_MAX = 4,
  parameter int P_W   = cnt_width(P_MAX)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           inc,
  input  logic           dec,
  output logic [P_W-1:0] cnt,
  output logic           full,
  output logic           empty
);

  logic [P_W-1:0] cnt_q, cnt_d;
  logic           inc_eff, dec_eff;

  assign full  = (cnt_q == P_W'(P_MAX));
  assign empty = (cnt_q == '0);
  assign cnt   = cnt_q;

  // A response seen at zero is spurious and is ignored.
  // An accept at full is only taken when a response frees a slot.
  always_comb begin
    dec_eff = dec && !empty;
    inc_eff = inc && (!full || dec_eff);
    cnt_d   = cnt_q;
    case ({inc_eff, dec_eff})
      2'b10:   cnt_d = cnt_q + P_W'(1);
      2'b01:   cnt_d = cnt_q - P_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ammrv2axi_pipe.sv
// Pipelined Avalon-MM (readdatavalid) slave to AXI4-Lite master bridge.
// Define AMMRV2AXI_WRRESP_EN to add amm_writeresponsevalid and forward bresp.
module ammrv2axi_pipe
  import ammrv2axi_pkg::*;
#(
  parameter int P_ASIZE  = 32,
  parameter int P_DBYTES = 4,
  parameter int P_MAX_RD = 4,
  parameter int P_MAX_WR = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [P_ASIZE-1:0]    amm_address,
  input  logic [8*P_DBYTES-1:0] amm_writedata,
  input  logic [P_DBYTES-1:0]   amm_byteenable,
  input  logic                  amm_read,
  input  logic                  amm_write,
  output logic                  amm_waitrequest,
  output logic [8*P_DBYTES-1:0] amm_readdata,
  output logic                  amm_readdatavalid,
  output logic [1:0]            amm_response,
`ifdef AMMRV2AXI_WRRESP_EN
  output logic                  amm_writeresponsevalid,
`endif
  output logic [P_ASIZE-1:0]    axi_awaddr,
  output logic                  axi_awvalid,
  input  logic                  axi_awready,
  output logic [8*P_DBYTES-1:0] axi_wdata,
  output logic [P_DBYTES-1:0]   axi_wstrb,
  output logic                  axi_wvalid,
  input  logic                  axi_wready,
  input  logic [1:0]            axi_bresp,
  input  logic                  axi_bvalid,
  output logic                  axi_bready,
  output logic [P_ASIZE-1:0]    axi_araddr,
  output logic [2:0]            axi_arsize,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  input  logic [8*P_DBYTES-1:0] axi_rdata,
  input  logic [1:0]            axi_rresp,
  input  logic                  axi_rvalid,
  output logic                  axi_rready
);

  localparam int DW   = 8 * P_DBYTES;
  localparam int RD_W = cnt_width(P_MAX_RD);
  localparam int WR_W = cnt_width(P_MAX_WR);

  logic               awvalid_q, awvalid_d;
  logic               wvalid_q, wvalid_d;
  logic               arvalid_q, arvalid_d;
  logic [P_ASIZE-1:0] awaddr_q, awaddr_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic [P_DBYTES-1:0] wstrb_q, wstrb_d;
  logic [P_ASIZE-1:0] araddr_q, araddr_d;
  logic [2:0]         arsize_q, arsize_d;

  logic [RD_W-1:0] rd_cnt;
  logic [WR_W-1:0] wr_cnt;
  logic            rd_full, rd_empty, wr_full, wr_empty;
  logic            aw_free, w_free, ar_free;
  logic            rd_room, wr_room, rd_drained, wr_drained;
  logic            wr_accept, rd_accept;
  logic [7:0]      be_ext;

  ammrv2axi_ostcnt #(.P_MAX(P_MAX_RD), .P_W(RD_W)) u_rd_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (rd_accept),
    .dec   (axi_rvalid),
    .cnt   (rd_cnt),
    .full  (rd_full),
    .empty (rd_empty)
  );

  ammrv2axi_ostcnt #(.P_MAX(P_MAX_WR), .P_W(WR_W)) u_wr_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (wr_accept),
    .dec   (axi_bvalid),
    .cnt   (wr_cnt),
    .full  (wr_full),
    .empty (wr_empty)
  );

  // A slot is usable when empty or when its handshake completes this cycle.
  // A response arriving this cycle already counts as freeing its slot.
  assign aw_free    = !awvalid_q || axi_awready;
  assign w_free     = !wvalid_q  || axi_wready;
  assign ar_free    = !arvalid_q || axi_arready;
  assign rd_room    = !rd_full || axi_rvalid;
  assign wr_room    = !wr_full || axi_bvalid;
  assign rd_drained = rd_empty || ((rd_cnt == RD_W'(1)) && axi_rvalid);
  assign wr_drained = wr_empty || ((wr_cnt == WR_W'(1)) && axi_bvalid);

  assign wr_accept = !reset && amm_write && aw_free && w_free && wr_room && rd_drained;
  assign rd_accept = !reset && amm_read && !amm_write && ar_free && rd_room && wr_drained;
  assign amm_waitrequest = !(wr_accept || rd_accept);

  assign be_ext = 8'(amm_byteenable);

  // A valid only drops on its own handshake; payload only loads on accept.
  always_comb begin
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    araddr_d  = araddr_q;
    arsize_d  = arsize_q;
    if (axi_awready) awvalid_d = 1'b0;
    if (axi_wready)  wvalid_d  = 1'b0;
    if (axi_arready) arvalid_d = 1'b0;
    if (wr_accept) begin
      awvalid_d = 1'b1;
      wvalid_d  = 1'b1;
      awaddr_d  = amm_address;
      wdata_d   = amm_writedata;
      wstrb_d   = amm_byteenable;
    end
    if (rd_accept) begin
      arvalid_d = 1'b1;
      araddr_d  = amm_address;
      arsize_d  = calc_arsize(be_ext, P_DBYTES);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      araddr_q  <= '0;
      arsize_q  <= '0;
    end else begin
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      araddr_q  <= araddr_d;
      arsize_q  <= arsize_d;
    end
  end

  assign axi_awvalid = awvalid_q;
  assign axi_wvalid  = wvalid_q;
  assign axi_arvalid = arvalid_q;
  assign axi_awaddr  = awaddr_q;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = wstrb_q;
  assign axi_araddr  = araddr_q;
  assign axi_arsize  = arsize_q;
  assign axi_bready  = 1'b1;
  assign axi_rready  = 1'b1;

  assign amm_readdata      = axi_rdata;
  assign amm_readdatavalid = axi_rvalid;

`ifdef AMMRV2AXI_WRRESP_EN
  // Read and write responses cannot overlap, so bvalid selects the source.
  assign amm_writeresponsevalid = axi_bvalid;
  assign amm_response = axi_bvalid ? axi_bresp : axi_rresp;
`else
  logic unused_bresp;
  assign unused_bresp = ^axi_bresp;
  assign amm_response = axi_rresp;
`endif

endmodule
